pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic successor to the fixed MEM/WB latch, usable for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries NUM_FIELDS data words plus a CTRL_W control bundle, with a truly clocked register stage.
- Adds a valid/ready handshake, a 2-entry skid buffer so in_ready is registered, a synchronous flush, and bubble insertion with control zeroed.
- Sits between adjacent pipeline stages. Hazard/branch logic drives flush and out_ready.

Parameters:
- DATA_W, 32, width of each data field (ir, aluout, readdata, ...).
- NUM_FIELDS, 3, number of DATA_W fields carried.
- CTRL_W, 2, control-bit count (e.g. RegWrite, MemtoReg); all zero means NOP.
- CNT_W, 16, perf counter width (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream stage holds a valid instruction.
- in_ready  out  1  stage can accept; registered.
- in_data  in  NUM_FIELDS*DATA_W  packed fields; field k is bits [k*DATA_W +: DATA_W].
- in_ctrl  in  CTRL_W  control bundle.
- flush  in  1  squash all held entries and the current input.
- out_valid  out  1  downstream holds a valid instruction.
- out_ready  in  1  downstream accepts; a low value is a stall.
- out_data  out  NUM_FIELDS*DATA_W  registered fields.
- out_ctrl  out  CTRL_W  registered control, forced to 0 whenever out_valid=0.

Behaviour:
- Storage: main register M (drives outputs) and skid register S. Each has data, ctrl and valid.
- States:
  - EMPTY: M and S invalid.
  - ONE: M valid, S invalid.
  - TWO: M and S valid.
- Handshakes: accept = in_valid & in_ready; emit = out_valid & out_ready. All updates happen on the rising clk edge.
- in_ready = (state != TWO). It is a registered signal and never combinationally depends on out_ready.
- Latency: data accepted at edge N appears on out_* after edge N (1 cycle) when M is free or emitting.
- Transitions (no flush):
  - EMPTY: accept -> ONE with M=in.
  - ONE, accept & emit: M=in, stay ONE.
  - ONE, accept & !emit: S=in -> TWO.
  - ONE, !accept & emit -> EMPTY.
  - TWO, emit: M=S -> ONE (in_ready rises the next cycle). TWO with !emit holds.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- Flush: synchronous and highest priority over accept and emit.
  - Next state is EMPTY, M/S valid cleared, M/S ctrl cleared to 0, and the input presented that cycle is discarded.
  - Data fields are not required to clear.
- Reset: asynchronous, takes effect immediately.
  - out_valid=0, in_ready=1, out_ctrl=0, out_data=0, S contents 0, state EMPTY.
  - Reset mid-transfer loses all held entries.
- Bubble: while out_valid=0, out_ctrl=0, so downstream sees a NOP (no RegWrite/MemWrite).
- A stall (out_ready=0) holds out_data/out_ctrl stable, bit-exact, until emit.
- Simultaneous flush and rst: rst wins.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- When defined, adds two outputs: stall_cnt [CNT_W] and bubble_cnt [CNT_W].
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments each cycle with !out_valid & out_ready.
  - Both saturate at all-ones, clear on rst, and are not cleared by flush.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - localparams for the default DATA_W/CTRL_W.
  - typedef of the stage state enum (EMPTY, ONE, TWO).
  - field index constants for MEM/WB use (FLD_IR=0, FLD_ALUOUT=1, FLD_RDATA=2).
  - control bit indices (CTL_REGWRITE=0, CTL_MEMTOREG=1).
- One natural sub-module, sat_counter (width CNT_W, inc, clear), instantiated twice only under PIPE_STAGE_PERF_EN.

Test Plan:
1. Reset then stream: rst pulse, then in_valid=1 with ir=0x8C220004, aluout=0x10, rdata=0xDEADBEEF, ctrl=2'b11, out_ready=1.
   -> out_valid=1 with identical fields one cycle later; in_ready stays 1.
2. Stall/skid: send A=0x11, B=0x22, C=0x33 back-to-back with out_ready=0 from cycle 1.
   -> A is held on out; B sits in S; in_ready=0 from the cycle after B; C is not accepted.
   -> Raising out_ready yields A, B, C in order with no loss or duplication.
3. Flush: flush=1 in state TWO while in_valid=1 with ctrl=2'b11.
   -> Next cycle out_valid=0, out_ctrl=2'b00, in_ready=1, and the squashed input never appears.
4. Async reset mid-stall: assert rst between edges in state TWO.
   -> out_valid, out_ctrl and out_data go to 0 immediately, without a clock; state is EMPTY after release.
5. Parameter sweep: DATA_W=8, NUM_FIELDS=5, CTRL_W=4, field k = k+1.
   -> Packed out_data matches field-for-field; out_ctrl=0 whenever out_valid=0.
6. With PIPE_STAGE_PERF_EN, CNT_W=2: 5 stall cycles -> stall_cnt=3 (saturated); 2 idle cycles with out_ready=1 -> bubble_cnt=2; flush leaves both unchanged.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and stage state type for the elastic pipeline register.
// Field/control indices describe the MEM/WB usage of the stage.
package pipe_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_NUM_FIELDS = 3;
   localparam int DEF_CTRL_W     = 2;
   localparam int DEF_CNT_W      = 16;

   localparam int FLD_IR     = 0;
   localparam int FLD_ALUOUT = 1;
   localparam int FLD_RDATA  = 2;

   localparam int CTL_REGWRITE = 0;
   localparam int CTL_MEMTOREG = 1;

   // Occupancy of the stage: nothing, main register only, main plus skid.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle around one pipeline stage register: upstream side,
// downstream side and the flush request from hazard logic.
interface pipe_stage_reg_if #(
   parameter int DATA_W     = 32,
   parameter int NUM_FIELDS = 3,
   parameter int CTRL_W     = 2
) ();

   logic                         in_valid;
   logic                         in_ready;
   logic [NUM_FIELDS*DATA_W-1:0] in_data;
   logic [CTRL_W-1:0]            in_ctrl;
   logic                         flush;
   logic                         out_valid;
   logic                         out_ready;
   logic [NUM_FIELDS*DATA_W-1:0] out_data;
   logic [CTRL_W-1:0]            out_ctrl;

   // Surrounding pipeline (upstream producer, downstream consumer, hazard unit).
   modport master (
      output in_valid, in_data, in_ctrl, flush, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl
   );

   // The stage register itself.
   modport slave (
      input  in_valid, in_data, in_ctrl, flush, out_ready,
      output in_ready, out_valid, out_data, out_ctrl
   );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for stage performance monitoring.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (inc && (cnt != {W{1'b1}}))
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage: main register plus one skid entry, registered
// in_ready, synchronous flush. PIPE_STAGE_PERF_EN adds stall/bubble counters.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int NUM_FIELDS = DEF_NUM_FIELDS,
   parameter int CTRL_W     = DEF_CTRL_W,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   pipe_stage_reg_if.slave  bus
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
`endif
);

   localparam int PW = NUM_FIELDS * DATA_W;

   stage_state_e      state, state_nxt;
   logic [PW-1:0]     m_data, s_data;
   logic [CTRL_W-1:0] m_ctrl, s_ctrl;
   logic              ready_q;

   logic accept, emit;
   logic ld_m_in, ld_m_s, ld_s_in, clr_m, clr_s;

   assign accept = bus.in_valid & ready_q;
   assign emit   = (state != EMPTY) & bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= EMPTY;
         ready_q <= 1'b1;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt != TWO);
      end
   end

   always_comb begin
      state_nxt = state;
      ld_m_in   = 1'b0;
      ld_m_s    = 1'b0;
      ld_s_in   = 1'b0;
      clr_m     = 1'b0;
      clr_s     = 1'b0;
      if (bus.flush) begin
         state_nxt = EMPTY;
         clr_m     = 1'b1;
         clr_s     = 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state_nxt = ONE;
                  ld_m_in   = 1'b1;
               end
            end
            ONE: begin
               if (accept && emit) begin
                  ld_m_in = 1'b1;
               end else if (accept) begin
                  state_nxt = TWO;
                  ld_s_in   = 1'b1;
               end else if (emit) begin
                  state_nxt = EMPTY;
                  clr_m     = 1'b1;
               end
            end
            TWO: begin
               // ready_q is low here, so only the drain path exists
               if (emit) begin
                  state_nxt = ONE;
                  ld_m_s    = 1'b1;
                  clr_s     = 1'b1;
               end
            end
            default: begin
               state_nxt = EMPTY;
               clr_m     = 1'b1;
               clr_s     = 1'b1;
            end
         endcase
      end
   end

   // Control is zeroed whenever an entry goes invalid so a bubble reads as a NOP;
   // data fields are left as-is on flush/drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_data <= '0;
         m_ctrl <= '0;
      end else if (ld_m_in) begin
         m_data <= bus.in_data;
         m_ctrl <= bus.in_ctrl;
      end else if (ld_m_s) begin
         m_data <= s_data;
         m_ctrl <= s_ctrl;
      end else if (clr_m) begin
         m_ctrl <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_data <= '0;
         s_ctrl <= '0;
      end else if (ld_s_in) begin
         s_data <= bus.in_data;
         s_ctrl <= bus.in_ctrl;
      end else if (clr_s) begin
         s_ctrl <= '0;
      end
   end

   assign bus.in_ready  = ready_q;
   assign bus.out_valid = (state != EMPTY);
   assign bus.out_data  = m_data;
   assign bus.out_ctrl  = m_ctrl;

`ifdef PIPE_STAGE_PERF_EN
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   ((state != EMPTY) & ~bus.out_ready),
      .clear (1'b0),
      .cnt   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   ((state == EMPTY) & bus.out_ready),
      .clear (1'b0),
      .cnt   (bubble_cnt)
   );
`else
   // Counter width only matters when the counters exist; keep it referenced.
   if (CNT_W < 1) begin : g_cnt_w_unused
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed plan steps plus random traffic against
// a capacity-2 FIFO reference model; PIPE_STAGE_PERF_EN also checks counters.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int DW  = 32, NF  = 3, CW  = 2;
   localparam int DW2 = 8,  NF2 = 5, CW2 = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_stage_reg_if #(.DATA_W(DW),  .NUM_FIELDS(NF),  .CTRL_W(CW))  b1 ();
   pipe_stage_reg_if #(.DATA_W(DW2), .NUM_FIELDS(NF2), .CTRL_W(CW2)) b2 ();

`ifdef PIPE_STAGE_PERF_EN
   logic [15:0] stall1, bubble1;
   logic [1:0]  stall2, bubble2;
`endif

   pipe_stage_reg #(.DATA_W(DW), .NUM_FIELDS(NF), .CTRL_W(CW), .CNT_W(16)) u1 (
      .clk (clk),
      .rst (rst),
      .bus (b1)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt (stall1), .bubble_cnt (bubble1)
`endif
   );

   pipe_stage_reg #(.DATA_W(DW2), .NUM_FIELDS(NF2), .CTRL_W(CW2), .CNT_W(2)) u2 (
      .clk (clk),
      .rst (rst),
      .bus (b2)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt (stall2), .bubble_cnt (bubble2)
`endif
   );

   int errors = 0;
   int checks = 0;

   typedef logic [CW+NF*DW-1:0] ent_t;
   ent_t q[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // The stage must look like a 2-deep FIFO whose head is on out_*.
   task automatic check_model();
      chk("in_ready", b1.in_ready, q.size() < 2);
      chk("out_valid", b1.out_valid, q.size() > 0);
      if (q.size() > 0) begin
         chk("out_data", b1.out_data, q[0][NF*DW-1:0]);
         chk("out_ctrl", b1.out_ctrl, q[0][CW+NF*DW-1 -: CW]);
      end else begin
         chk("bubble_ctrl", b1.out_ctrl, 0);
      end
   endtask

   task automatic cycle();
      bit acc, em;
      acc = b1.in_valid && (q.size() < 2);
      em  = b1.out_ready && (q.size() > 0);
      @(posedge clk);
      if (b1.flush) q.delete();
      else begin
         if (em)  void'(q.pop_front());
         if (acc) q.push_back({b1.in_ctrl, b1.in_data});
      end
      @(negedge clk);
      check_model();
   endtask

   task automatic set_in(input logic v, input logic [31:0] w, input logic [CW-1:0] c);
      b1.in_valid = v;
      b1.in_data  = {w, w, w};
      b1.in_ctrl  = c;
   endtask

   logic [NF2*DW2-1:0] exp5;

   initial begin
      rst = 1'b1;
      b1.in_valid = 0; b1.in_data = '0; b1.in_ctrl = '0; b1.flush = 0; b1.out_ready = 0;
      b2.in_valid = 0; b2.in_data = '0; b2.in_ctrl = '0; b2.flush = 0; b2.out_ready = 0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_data", b1.out_data, 0);
      rst = 1'b0;
      check_model();
`ifdef PIPE_STAGE_PERF_EN
      chk("rst_stall1", stall1, 0);
      chk("rst_bubble1", bubble1, 0);
`endif

      // 1: reset then stream
      b1.in_valid = 1;
      b1.in_data  = {32'hDEADBEEF, 32'h00000010, 32'h8C220004};
      b1.in_ctrl  = 2'b11;
      b1.out_ready = 1;
      cycle();
      chk("t1_ir",    b1.out_data[FLD_IR*DW +: DW],     32'h8C220004);
      chk("t1_alu",   b1.out_data[FLD_ALUOUT*DW +: DW], 32'h00000010);
      chk("t1_rdata", b1.out_data[FLD_RDATA*DW +: DW],  32'hDEADBEEF);
      chk("t1_regwr", b1.out_ctrl[CTL_REGWRITE], 1'b1);
      chk("t1_m2r",   b1.out_ctrl[CTL_MEMTOREG], 1'b1);
      chk("t1_ready", b1.in_ready, 1'b1);
      cycle();
      chk("t1_ready2", b1.in_ready, 1'b1);
      set_in(0, 32'h0, 2'b00);
      cycle();

      // 2: stall / skid
      b1.out_ready = 0;
      set_in(1, 32'h11, 2'b01);
      cycle();
      set_in(1, 32'h22, 2'b10);
      cycle();
      chk("t2_ready_lo", b1.in_ready, 1'b0);
      set_in(1, 32'h33, 2'b11);
      cycle();
      chk("t2_hold_A", b1.out_data[31:0], 32'h11);
      chk("t2_ready_lo2", b1.in_ready, 1'b0);
      b1.out_ready = 1;
      cycle();
      chk("t2_B", b1.out_data[31:0], 32'h22);
      chk("t2_ready_up", b1.in_ready, 1'b1);
      cycle();
      chk("t2_C", b1.out_data[31:0], 32'h33);
      set_in(0, 32'h0, 2'b00);
      cycle();
      chk("t2_drained", b1.out_valid, 1'b0);

      // 3: flush in TWO with a live input
      b1.out_ready = 0;
      set_in(1, 32'h44, 2'b01);
      cycle();
      set_in(1, 32'h45, 2'b10);
      cycle();
      set_in(1, 32'h55, 2'b11);
      b1.flush = 1;
      cycle();
      chk("t3_valid", b1.out_valid, 1'b0);
      chk("t3_ctrl",  b1.out_ctrl, 2'b00);
      chk("t3_ready", b1.in_ready, 1'b1);
      b1.flush = 0;
      set_in(0, 32'h0, 2'b00);
      b1.out_ready = 1;
      cycle();
      chk("t3_no_ghost", b1.out_valid, 1'b0);
      cycle();

      // 4: async reset while stalled in TWO
      b1.out_ready = 0;
      set_in(1, 32'h66, 2'b11);
      cycle();
      set_in(1, 32'h77, 2'b11);
      cycle();
      set_in(0, 32'h0, 2'b00);
      #2 rst = 1'b1;
      #1;
      chk("t4_valid", b1.out_valid, 1'b0);
      chk("t4_ctrl",  b1.out_ctrl, 0);
      chk("t4_data",  b1.out_data, 0);
      chk("t4_ready", b1.in_ready, 1'b1);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      check_model();
      b1.out_ready = 1;
      cycle();

      // random traffic against the FIFO model
      for (int i = 0; i < 400; i++) begin
         b1.in_valid  = ($urandom_range(0, 3) != 0);
         b1.in_data   = {$urandom, $urandom, $urandom};
         b1.in_ctrl   = CW'($urandom);
         b1.out_ready = ($urandom_range(0, 2) != 0);
         b1.flush     = ($urandom_range(0, 19) == 0);
         cycle();
      end
      b1.in_valid = 0; b1.flush = 0; b1.out_ready = 0;

      // 5/6: narrow-field instance, stall then bubbles
`ifdef PIPE_STAGE_PERF_EN
      chk("t6_stall0",  stall2, 0);
      chk("t6_bubble0", bubble2, 0);
`endif
      for (int k = 0; k < NF2; k++) exp5[k*DW2 +: DW2] = DW2'(k + 1);
      b2.in_valid = 1;
      b2.in_data  = exp5;
      b2.in_ctrl  = 4'hA;
      b2.out_ready = 0;
      @(posedge clk);
      @(negedge clk);
      b2.in_valid = 0;
      b2.in_data  = '0;
      chk("t5_valid", b2.out_valid, 1'b1);
      chk("t5_packed", b2.out_data, 40'h0504030201);
      for (int k = 0; k < NF2; k++)
         chk($sformatf("t5_field%0d", k), b2.out_data[k*DW2 +: DW2], k + 1);
      chk("t5_ctrl", b2.out_ctrl, 4'hA);
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("t5_stall_hold", b2.out_data, 40'h0504030201);
      chk("t5_stall_ctrl", b2.out_ctrl, 4'hA);
`ifdef PIPE_STAGE_PERF_EN
      chk("t6_stall_sat", stall2, 2'd3);
      chk("t6_bubble_z", bubble2, 0);
`endif
      b2.out_ready = 1;
      @(posedge clk);
      @(negedge clk);
      chk("t5_empty", b2.out_valid, 1'b0);
      chk("t5_bubble_ctrl", b2.out_ctrl, 0);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
`ifdef PIPE_STAGE_PERF_EN
      chk("t6_bubble", bubble2, 2'd2);
`endif
      b2.out_ready = 0;
      b2.flush = 1;
      @(posedge clk);
      @(negedge clk);
      b2.flush = 0;
      chk("t5_flush_ctrl", b2.out_ctrl, 0);
`ifdef PIPE_STAGE_PERF_EN
      chk("t6_flush_stall", stall2, 2'd3);
      chk("t6_flush_bubble", bubble2, 2'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
